// File: rtl/subpel_row_sequencer.sv
// Vertical-pass row sequencer for subpixel interpolation: fetches ROWS rows per block and flags BLK result rows.
// Optional SUBPEL_STALL_CNT_EN adds a saturating 16-bit stall_cnt output counting unacknowledged fetch cycles.
module subpel_row_sequencer #(
  parameter int ROWS     = 15,
  parameter int BLK      = 8,
  parameter int PIPE_LAT = 2,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_row,
  output logic              busy,
  output logic              done,
  output logic              row_req,
  output logic [ADDR_W-1:0] row_addr,
  input  logic              row_ack,
  output logic              dp_load,
  output logic [3:0]        dp_sel,
  output logic              out_we,
  output logic [2:0]        out_row
`ifdef SUBPEL_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int         DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] TAP_OFF  = 4'(ROWS - BLK);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] base_r, base_nxt_s;
  logic [3:0]        row_cnt_r, row_cnt_nxt_s;
  logic [DRN_W-1:0]  drain_cnt_r, drain_cnt_nxt_s;
  logic [PIPE_LAT-1:0]       pipe_vld_r;
  logic [PIPE_LAT-1:0][2:0]  pipe_row_r;

  logic       row_req_s;
  logic       load_s;
  logic       busy_s;
  logic       done_s;
  logic       push_vld_s;
  logic [2:0] out_off_s;

  // Control state and block context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      base_r      <= {ADDR_W{1'b0}};
      row_cnt_r   <= 4'd0;
      drain_cnt_r <= {DRN_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      base_r      <= base_nxt_s;
      row_cnt_r   <= row_cnt_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  // Next-state and fetch-handshake decode.
  always_comb begin
    state_nxt_s     = state_r;
    base_nxt_s      = base_r;
    row_cnt_nxt_s   = row_cnt_r;
    drain_cnt_nxt_s = drain_cnt_r;
    row_req_s       = 1'b0;
    load_s          = 1'b0;
    busy_s          = 1'b0;
    done_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          base_nxt_s    = base_row;
          row_cnt_nxt_s = 4'd0;
          state_nxt_s   = FETCH;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      FETCH: begin
        busy_s    = 1'b1;
        row_req_s = 1'b1;
        if (row_ack) begin
          load_s = 1'b1;
          if (row_cnt_r == LAST_ROW) begin
            state_nxt_s     = DRAIN;
            drain_cnt_nxt_s = {DRN_W{1'b0}};
          end else begin
            row_cnt_nxt_s   = row_cnt_r + 4'd1;
          end
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DRAIN: begin
        busy_s = 1'b1;
        if (drain_cnt_r == DRN_LAST) begin
          state_nxt_s     = DONE;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r + {{(DRN_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        busy_s      = 1'b1;
        done_s      = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Only rows past the filter's leading taps produce a result row.
  assign push_vld_s = load_s && (row_cnt_r >= TAP_OFF);
  assign out_off_s  = 3'(row_cnt_r - TAP_OFF);

  // Result-valid delay line; shifts every cycle so stalls never drop or duplicate results.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_r <= {PIPE_LAT{1'b0}};
      pipe_row_r <= {(PIPE_LAT*3){1'b0}};
    end else begin
      pipe_vld_r[0] <= push_vld_s;
      pipe_row_r[0] <= push_vld_s ? out_off_s : 3'd0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_row_r[i] <= pipe_row_r[i-1];
      end
    end
  end

  assign busy     = busy_s;
  assign done     = done_s;
  assign row_req  = row_req_s;
  assign dp_load  = load_s;
  assign row_addr = row_req_s ? (base_r + ADDR_W'(row_cnt_r)) : {ADDR_W{1'b0}};
  assign dp_sel   = row_req_s ? row_cnt_r : 4'd0;
  assign out_we   = pipe_vld_r[PIPE_LAT-1];
  assign out_row  = pipe_row_r[PIPE_LAT-1];

`ifdef SUBPEL_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of fetch cycles the memory left unacknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == IDLE) && start) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == FETCH) && !row_ack && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_subpel_row_sequencer.sv
// Directed self-checking bench for subpel_row_sequencer; stall counter checks run when SUBPEL_STALL_CNT_EN is defined.
module tb_subpel_row_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_row;
  logic       busy;
  logic       done;
  logic       row_req;
  logic [7:0] row_addr;
  logic       row_ack;
  logic       dp_load;
  logic [3:0] dp_sel;
  logic       out_we;
  logic [2:0] out_row;
`ifdef SUBPEL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  subpel_row_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_row (base_row),
    .busy     (busy),
    .done     (done),
    .row_req  (row_req),
    .row_addr (row_addr),
    .row_ack  (row_ack),
    .dp_load  (dp_load),
    .dp_sel   (dp_sel),
    .out_we   (out_we),
    .out_row  (out_row)
`ifdef SUBPEL_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // {busy, done, row_req, dp_load, out_we, out_row, dp_sel, row_addr}; idle fields masked to 0
  function automatic logic [31:0] obs_vec();
    return 32'({busy, done, row_req, dp_load, out_we,
                (out_we ? out_row : 3'd0), (row_req ? dp_sel : 4'd0), (row_req ? row_addr : 8'd0)});
  endfunction

  // memory withholds ack for l cycles starting at cycle 5 (row index 4)
  function automatic bit ack_at(input int c, input int l);
    return !((c >= 5) && (c < 5 + l));
  endfunction

  // Closed-form expectations for cycle c after start accepted at cycle 0
  function automatic logic [31:0] exp_vec(input int c, input logic [7:0] base, input int l);
    bit req, ld, we, dn, bs;
    int idx;
    logic [7:0] addr;
    logic [2:0] orow;
    req  = (c >= 1) && (c <= 15 + l);
    idx  = (c <= 5) ? c - 1 : ((c < 5 + l) ? 4 : c - 1 - l);
    addr = base + 8'(idx);
    ld   = req && ack_at(c, l);
    we   = (c >= 10 + l) && (c <= 17 + l);
    orow = we ? 3'(c - 10 - l) : 3'd0;
    dn   = (c == 18 + l);
    bs   = (c >= 1) && (c <= 18 + l);
    return 32'({bs, dn, req, ld, we, orow, (req ? 4'(idx) : 4'd0), (req ? addr : 8'd0)});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a clock edge in IDLE; start is asserted this cycle (cycle 0).
  task automatic run_block(input logic [7:0] base, input int l, input bit junk);
    int we_n = 0;
    int ld_n = 0;
    start    = 1'b1;
    base_row = base;
    row_ack  = 1'b1;
    #3;
    chk_val($sformatf("idle_b%0d", base), obs_vec(), exp_vec(0, base, l));
    for (int c = 1; c <= 18 + l; c++) begin
      tick();
      start    = junk && ((c == 3) || (c == 18 + l));
      base_row = start ? 8'd99 : base;
      row_ack  = ack_at(c, l);
      #3;
      chk_val($sformatf("b%0d_l%0d_c%0d", base, l, c), obs_vec(), exp_vec(c, base, l));
      we_n += int'(out_we);
      ld_n += int'(dp_load);
    end
    chk_val($sformatf("we_count_b%0d", base), 32'(we_n), 32'd8);
    chk_val($sformatf("load_count_b%0d", base), 32'(ld_n), 32'd15);
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    row_ack  = 1'b0;
    base_row = 8'd0;
    tick();
    tick();
    #3;
    chk_val("reset_state", obs_vec(), 32'd0);
    rst = 1'b0;
    tick();

    run_block(8'd0, 0, 1'b0);
    run_block(8'd0, 3, 1'b0);
`ifdef SUBPEL_STALL_CNT_EN
    chk_val("stall_cnt_3", 32'(stall_cnt), 32'd3);
`endif
    run_block(8'd250, 0, 1'b0);
    run_block(8'd5, 0, 1'b1);
    run_block(8'd7, 0, 1'b0);

    // reset in the cycle after row 9 is loaded drops everything in flight
    start    = 1'b1;
    base_row = 8'd0;
    row_ack  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start   = 1'b0;
      row_ack = 1'b1;
      #3;
      chk_val($sformatf("pre_rst_c%0d", c), obs_vec(), exp_vec(c, 8'd0, 0));
    end
    tick();
    rst     = 1'b1;
    row_ack = 1'b0;
    tick();
    rst = 1'b0;
    #3;
    chk_val("after_rst", obs_vec(), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      #3;
      chk_val($sformatf("post_rst_%0d", i), 32'({out_we, done, busy, row_req}), 32'd0);
    end
    tick();
    run_block(8'd20, 0, 1'b0);

`ifdef SUBPEL_STALL_CNT_EN
    begin
      int  we_n = 0;
      int  ld_n = 0;
      bit  seen = 1'b0;
      start    = 1'b1;
      base_row = 8'd40;
      row_ack  = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 70000; i++) begin
        tick();
      end
      #3;
      chk_val("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
      chk_val("stall_addr_hold", 32'({row_req, dp_load, row_addr}), 32'({1'b1, 1'b0, 8'd40}));
      row_ack = 1'b1;
      #1;
      ld_n = int'(dp_load);
      for (int i = 0; (i < 100) && !seen; i++) begin
        tick();
        #3;
        we_n += int'(out_we);
        ld_n += int'(dp_load);
        if (done) begin
          seen = 1'b1;
        end
      end
      chk_val("sat_done_seen", 32'(seen), 32'd1);
      chk_val("sat_we_count", 32'(we_n), 32'd8);
      chk_val("sat_load_count", 32'(ld_n), 32'd15);
      tick();
      #3;
      chk_val("stall_hold_idle", 32'(stall_cnt), 32'h0000FFFF);
      start    = 1'b1;
      base_row = 8'd0;
      tick();
      start = 1'b0;
      #3;
      chk_val("stall_clear", 32'(stall_cnt), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/subpel_row_sequencer.md
Name: subpel_row_sequencer

Overview:
- Controller that sequences the vertical pass of subpixel_interpolation: fetches the ROWS integer-pixel rows of one block from row memory, feeds them to the datapath, and marks each result row as valid.
- Sits between the block-level scheduler (start/done) and the row memory (req/ack) plus the filter datapath (load/sel).
- Tracks filter pipeline latency so out_we lines up with the filtered rows.

Parameters:
- ROWS, 15, integer rows per block (BLK + 7, for the 8-tap filter)
- BLK, 8, output rows per block
- PIPE_LAT, 2, cycles from dp_load to filter result valid (>=1)
- ADDR_W, 8, row address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request one block; sampled only in IDLE
- base_row  in  ADDR_W  first row address; latched when start is accepted
- busy  out  1  high in FETCH, DRAIN, DONE
- done  out  1  one-cycle pulse in DONE
- row_req  out  1  row fetch request
- row_addr  out  ADDR_W  row address to fetch
- row_ack  in  1  memory accepts the request and drives the row this cycle
- dp_load  out  1  datapath latches the row (= row_req & row_ack)
- dp_sel  out  4  window index of the loaded row (0..ROWS-1)
- out_we  out  1  vertical result row valid
- out_row  out  3  result row index (0..BLK-1)

Behaviour:
- Reset (any state): state=IDLE; busy, done, row_req, dp_load, out_we = 0; row_addr, dp_sel, out_row = 0; row counter and pipeline shift register cleared. Reset mid-operation drops all in-flight rows, with no out_we and no done.
- IDLE:
  - start=1 latches base_row and sets row_cnt=0; next state is FETCH.
  - start in any other state is ignored, including the DONE cycle.
- FETCH:
  - row_req=1, row_addr=(base+row_cnt) mod 2^ADDR_W, dp_sel=row_cnt.
  - On row_ack: dp_load=1 (combinational), row_cnt increments.
  - Without ack: row_addr, dp_sel and row_cnt hold; row_req stays high.
  - Ack at row_cnt==ROWS-1 goes to DRAIN.
- Result tracking:
  - A load of row r >= 7 pushes {valid, r-7} into a PIPE_LAT-deep shift register.
  - The output stage drives out_we=1 and out_row=r-7 exactly PIPE_LAT cycles after that load.
  - The register shifts every cycle, including stall cycles, so stalls delay later results but never drop or duplicate them.
- DRAIN: lasts exactly PIPE_LAT cycles (row_req=0), then DONE.
- DONE: done=1 for one cycle; next state is IDLE.
- Per block: exactly BLK out_we pulses with out_row 0..BLK-1 in order, and exactly ROWS dp_load pulses.
- Latency (ack always high, start accepted at cycle 0):
  - Loads occur in cycles 1..15.
  - out_we occurs in cycles 10..17.
  - done occurs in cycle 18.
  - Earliest next accept is cycle 19.

Optional Feature:
- Macro: SUBPEL_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Increments each FETCH cycle with row_req & !row_ack.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst and on start acceptance; holds its value after done.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- rst, then start with base_row=0 and row_ack tied 1 -> row_addr 0..14 on cycles 1..15; out_we cycles 10..17 with out_row 0..7; done=1 only at cycle 18; busy=1 for cycles 1..18.
- Same stimulus with row_ack=0 for 3 cycles while row_addr=4 -> row_addr holds 4 and dp_load=0 for 3 cycles; out_we moves to cycles 13..20; done at 21; stall_cnt=3 (macro on).
- base_row=250, ADDR_W=8, ack=1 -> row_addr sequence 250..255, 0..8; 8 out_we pulses.
- rst asserted for one cycle after row 9 is loaded -> next cycle busy=0, row_req=0; no further out_we or done; new start with base_row=20 fetches 20..34 from row index 0.
- start pulsed during FETCH and during the DONE cycle -> ignored (no re-latch of base_row, exactly one done); start in the following IDLE cycle is accepted.
- Macro on, row_ack held 0 for 70000 cycles -> stall_cnt saturates at FFFF; then ack=1 completes the block normally; next start clears stall_cnt to 0.
